// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the pipeline/memory arbiter: FSM state encodings,
// the default memory latency and the word-alignment helper.
package cpu_mem_pkg;

   localparam int unsigned DEF_MEM_LAT = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_BUSY_I = 3'd1;
   localparam logic [2:0] ST_BUSY_D = 3'd2;
   localparam logic [2:0] ST_DONE_I = 3'd3;
   localparam logic [2:0] ST_DONE_D = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_BUSY_I = ST_BUSY_I,
      S_BUSY_D = ST_BUSY_D,
      S_DONE_I = ST_DONE_I,
      S_DONE_D = ST_DONE_D
   } arb_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Fixed-latency access counter: counts while enabled, flags terminal count
// (MEM_LAT-1), clear has priority over enable.
module mem_lat_counter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MEM_LAT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and
// load/store; data side wins ties, stall_o freezes the pipe until its ready pulse.
module unified_mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned MEM_LAT = DEF_MEM_LAT,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ready_o,
   input  logic        dm_rd_i,
   input  logic        dm_wr_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ready_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o
);

   arb_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        en_q, en_d;
   logic        we_q, we_d;
   logic        if_rdy_q, if_rdy_d;
   logic        dm_rdy_q, dm_rdy_d;
   logic        dm_req;
   logic        busy;
   logic        tc;

   assign dm_req = dm_rd_i | dm_wr_i;
   assign busy   = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);

   // Cleared on the terminal cycle so DONE/IDLE always see a zero count.
   mem_lat_counter #(
      .CNT_W   (CNT_W),
      .MEM_LAT (MEM_LAT)
   ) u_lat_cnt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr_i (~busy | tc),
      .en_i  (busy),
      .tc_o  (tc)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      en_d       = en_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_rdy_d   = 1'b0;
      dm_rdy_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // The MEM-stage instruction is older than the fetch, so it goes first.
            if (dm_req) begin
               state_d = S_BUSY_D;
               addr_d  = word_align(dm_addr_i);
               wdata_d = dm_wdata_i;
               we_d    = dm_wr_i;
               en_d    = 1'b1;
            end else if (if_req_i) begin
               state_d = S_BUSY_I;
               addr_d  = word_align(if_addr_i);
               we_d    = 1'b0;
               en_d    = 1'b1;
            end
         end
         S_BUSY_I: begin
            if (tc) begin
               state_d    = S_DONE_I;
               if_rdata_d = mem_rdata_i;
               if_rdy_d   = 1'b1;
               en_d       = 1'b0;
               we_d       = 1'b0;
            end
         end
         S_BUSY_D: begin
            if (tc) begin
               state_d    = S_DONE_D;
               dm_rdata_d = mem_rdata_i;
               dm_rdy_d   = 1'b1;
               en_d       = 1'b0;
               we_d       = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         en_q       <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_rdy_q   <= 1'b0;
         dm_rdy_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         en_q       <= en_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_rdy_q   <= if_rdy_d;
         dm_rdy_q   <= dm_rdy_d;
      end
   end

   assign mem_en_o    = en_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign if_ready_o  = if_rdy_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign dm_ready_o  = dm_rdy_q;

   // Combinational so the pipe advances in exactly the ready cycle.
   assign stall_o = (if_req_i & ~if_rdy_q) | (dm_req & ~dm_rdy_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance 0 uses MEM_LAT=2, instance 1 uses MEM_LAT=1.
// Both share the request inputs; only the selected instance may write the memory model.
module tb_unified_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        dm_rd;
   logic        dm_wr;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;

   logic [31:0] if_rdata  [2];
   logic        if_ready  [2];
   logic [31:0] dm_rdata  [2];
   logic        dm_ready  [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        stall     [2];

   logic [31:0] mem_arr [256];
   logic [31:0] ref_mem [256];

   int sel;
   int cyc;
   int errors;
   int checks;

   int          en_cnt;
   int          en_first;
   logic [31:0] en_addr;
   logic        en_we;
   bit          en_unstable;
   int          rdy_cnt;

   unified_mem_arbiter #(.MEM_LAT(2), .CNT_W(4)) u_dut_l2 (
      .clk_i (clk), .rst_n (rst_n),
      .if_req_i (if_req), .if_addr_i (if_addr),
      .if_rdata_o (if_rdata[0]), .if_ready_o (if_ready[0]),
      .dm_rd_i (dm_rd), .dm_wr_i (dm_wr), .dm_addr_i (dm_addr), .dm_wdata_i (dm_wdata),
      .dm_rdata_o (dm_rdata[0]), .dm_ready_o (dm_ready[0]),
      .mem_en_o (mem_en[0]), .mem_we_o (mem_we[0]), .mem_addr_o (mem_addr[0]),
      .mem_wdata_o (mem_wdata[0]), .mem_rdata_i (mem_rdata[0]),
      .stall_o (stall[0])
   );

   unified_mem_arbiter #(.MEM_LAT(1), .CNT_W(4)) u_dut_l1 (
      .clk_i (clk), .rst_n (rst_n),
      .if_req_i (if_req), .if_addr_i (if_addr),
      .if_rdata_o (if_rdata[1]), .if_ready_o (if_ready[1]),
      .dm_rd_i (dm_rd), .dm_wr_i (dm_wr), .dm_addr_i (dm_addr), .dm_wdata_i (dm_wdata),
      .dm_rdata_o (dm_rdata[1]), .dm_ready_o (dm_ready[1]),
      .mem_en_o (mem_en[1]), .mem_we_o (mem_we[1]), .mem_addr_o (mem_addr[1]),
      .mem_wdata_o (mem_wdata[1]), .mem_rdata_i (mem_rdata[1]),
      .stall_o (stall[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] init_word(input int i);
      return 32'h2002_0003 + i;
   endfunction

   // Memory macro: combinational read while enabled, write from the selected instance.
   assign mem_rdata[0] = mem_en[0] ? mem_arr[mem_addr[0][9:2]] : 32'h0;
   assign mem_rdata[1] = mem_en[1] ? mem_arr[mem_addr[1][9:2]] : 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en[sel] === 1'b1 && mem_we[sel] === 1'b1)
         mem_arr[mem_addr[sel][9:2]] = mem_wdata[sel];
   end

   always @(negedge clk) begin
      if (mem_en[sel] === 1'b1) begin
         if (en_cnt == 0) begin
            en_addr  = mem_addr[sel];
            en_we    = mem_we[sel];
            en_first = cyc;
         end else if (mem_addr[sel] !== en_addr || mem_we[sel] !== en_we) begin
            en_unstable = 1'b1;
         end
         en_cnt++;
      end
      if (if_ready[sel] === 1'b1 || dm_ready[sel] === 1'b1) rdy_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clr_mon();
      en_cnt      = 0;
      en_unstable = 1'b0;
      en_addr     = '0;
      en_we       = 1'b0;
      en_first    = -1;
   endtask

   // Waits for the chosen ready pulse; at=-1 on timeout. stall_hi tracks stall before it.
   task automatic wait_rdy(input bit d, output int at, output bit stall_hi);
      at       = -1;
      stall_hi = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ((d ? dm_ready[sel] : if_ready[sel]) === 1'b1) begin
            at = cyc;
            break;
         end
         if (stall[sel] !== 1'b1) stall_hi = 1'b0;
      end
   endtask

   // kind: 0 fetch, 1 load, 2 store, 3 load+store (store wins). Called at #1 after posedge.
   task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_rdata,
                          input string name);
      int t0, at, lat;
      bit is_d, is_st, st_hi;
      lat   = (sel == 0) ? 2 : 1;
      is_d  = (kind != 0);
      is_st = (kind >= 2);
      if_req   = (kind == 0);
      dm_rd    = (kind == 1 || kind == 3);
      dm_wr    = is_st;
      if_addr  = addr;
      dm_addr  = addr;
      dm_wdata = wdata;
      clr_mon();
      t0 = cyc;
      wait_rdy(is_d, at, st_hi);
      chk({name, " ready_cycle"}, at, t0 + lat + 1);
      chk({name, " stall_before"}, st_hi, 1'b1);
      chk({name, " stall_at_ready"}, stall[sel], 1'b0);
      chk({name, " en_cycles"}, en_cnt, lat);
      chk({name, " mem_addr"}, en_addr, exp_maddr);
      chk({name, " mem_we"}, {en_unstable, en_we}, {1'b0, is_st});
      if (!is_st)
         chk({name, " rdata"}, is_d ? dm_rdata[sel] : if_rdata[sel], exp_rdata);
      if (is_st) ref_mem[addr[9:2]] = wdata;
      @(posedge clk); #1;
      if_req = 1'b0;
      dm_rd  = 1'b0;
      dm_wr  = 1'b0;
   endtask

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_maddr;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int          t0, at;
      bit          st_hi;
      int          kind;
      logic [31:0] a, wd;

      errors = 0; checks = 0; cyc = 0; sel = 0; rdy_cnt = 0;
      clr_mon();
      rst_n = 1'b0; if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = init_word(i);
         ref_mem[i] = init_word(i);
      end

      vecs[0] = '{0, 32'h0000_0008, 32'h0,         32'h0000_0008, 32'h2002_0005};
      vecs[1] = '{2, 32'h0000_0013, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0};
      vecs[2] = '{1, 32'h0000_0012, 32'h0,         32'h0000_0010, 32'hDEAD_BEEF};
      vecs[3] = '{0, 32'h0000_0041, 32'h0,         32'h0000_0040, 32'h2002_0013};
      vecs[4] = '{3, 32'h0000_0023, 32'hCAFE_0001, 32'h0000_0020, 32'h0};
      vecs[5] = '{1, 32'h0000_0020, 32'h0,         32'h0000_0020, 32'hCAFE_0001};

      repeat (2) @(posedge clk);
      #1;
      chk("rst if_ready", if_ready[0], 1'b0);
      chk("rst dm_ready", dm_ready[0], 1'b0);
      chk("rst mem_en", mem_en[0], 1'b0);
      chk("rst mem_we", mem_we[0], 1'b0);
      chk("rst mem_addr", mem_addr[0], 32'h0);
      chk("rst mem_wdata", mem_wdata[0], 32'h0);
      chk("rst if_rdata", if_rdata[0], 32'h0);
      chk("rst dm_rdata", dm_rdata[0], 32'h0);
      chk("rst stall", stall[0], 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_maddr, vecs[i].exp_rdata, $sformatf("vec%0d", i));

      // Fetch and load together: load first, fetch granted after the load's DONE.
      if_req = 1'b1; if_addr = 32'h8; dm_rd = 1'b1; dm_addr = 32'h40;
      clr_mon();
      t0 = cyc;
      wait_rdy(1'b1, at, st_hi);
      chk("both dm_ready_cycle", at, t0 + 3);
      chk("both dm_rdata", dm_rdata[0], 32'h2002_0013);
      chk("both dm_addr", en_addr, 32'h40);
      chk("both stall_at_dm_ready", stall[0], 1'b1);
      @(posedge clk); #1;
      dm_rd = 1'b0;
      clr_mon();
      wait_rdy(1'b0, at, st_hi);
      chk("both if_ready_cycle", at, t0 + 7);
      chk("both if_grant_cycle", en_first, t0 + 5);
      chk("both if_rdata", if_rdata[0], 32'h2002_0005);
      chk("both stall_before_if", st_hi, 1'b1);
      @(posedge clk); #1;
      if_req = 1'b0;

      // Load raised while the fetch is in flight.
      if_req = 1'b1; if_addr = 32'h8;
      clr_mon();
      t0 = cyc;
      @(posedge clk); #1;
      dm_rd = 1'b1; dm_addr = 32'h20;
      wait_rdy(1'b0, at, st_hi);
      chk("late_ld if_ready_cycle", at, t0 + 3);
      chk("late_ld if_rdata", if_rdata[0], 32'h2002_0005);
      chk("late_ld if_addr_stable", {en_unstable, en_addr}, {1'b0, 32'h8});
      chk("late_ld stall_at_if_ready", stall[0], 1'b1);
      @(posedge clk); #1;
      if_req = 1'b0;
      clr_mon();
      wait_rdy(1'b1, at, st_hi);
      chk("late_ld dm_ready_cycle", at, t0 + 7);
      chk("late_ld dm_grant_cycle", en_first, t0 + 5);
      chk("late_ld dm_rdata", dm_rdata[0], 32'hCAFE_0001);
      chk("late_ld stall_held", st_hi, 1'b1);
      @(posedge clk); #1;
      dm_rd = 1'b0;

      // Reset in the second busy cycle of a load.
      dm_rd = 1'b1; dm_addr = 32'h10;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("abort busy_before_reset", mem_en[0], 1'b1);
      rst_n = 1'b0;
      dm_rd = 1'b0;
      #1;
      chk("abort mem_en", mem_en[0], 1'b0);
      chk("abort mem_addr", mem_addr[0], 32'h0);
      chk("abort dm_rdata", dm_rdata[0], 32'h0);
      chk("abort if_rdata", if_rdata[0], 32'h0);
      chk("abort dm_ready", dm_ready[0], 1'b0);
      chk("abort stall", stall[0], 1'b0);
      rdy_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort no_ready_pulse", rdy_cnt, 0);
      run_txn(1, 32'h10, 32'h0, 32'h10, 32'hDEAD_BEEF, "after_reset");

      // MEM_LAT=1 back-to-back random traffic against the reference memory.
      repeat (4) @(posedge clk);
      #1;
      sel = 1;
      for (int n = 0; n < 100; n++) begin
         kind = int'($urandom_range(0, 3));
         a    = 32'($urandom_range(0, 1023));
         wd   = $urandom;
         run_txn(kind, a, wd, a & 32'hFFFF_FFFC, ref_mem[a[9:2]], $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
